// File: rtl/li_rr_arbiter.sv
// rtl/li_rr_arbiter.sv - round-robin arbiter with per-owner burst lock feeding one registered valid/ready stage
module li_rr_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_PORTS  = 4,
   parameter int BURST_LEN  = 2,
   parameter int SEL_WIDTH  = $clog2(NUM_PORTS)
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_data,
   input  logic [NUM_PORTS-1:0]            i_valid,
   output logic [NUM_PORTS-1:0]            o_ready,
   output logic [DATA_WIDTH-1:0]           o_data,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic [SEL_WIDTH-1:0]            o_grant
);

   localparam int CNT_WIDTH = $clog2(BURST_LEN + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_RELOAD = CNT_WIDTH'(BURST_LEN - 1);
   localparam logic [SEL_WIDTH-1:0] LAST_PORT  = SEL_WIDTH'(NUM_PORTS - 1);

   function automatic logic [SEL_WIDTH-1:0] next_port(input logic [SEL_WIDTH-1:0] p);
      return (p == LAST_PORT) ? '0 : p + SEL_WIDTH'(1);
   endfunction

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [SEL_WIDTH-1:0]  grant_q, grant_d;
   logic [SEL_WIDTH-1:0]  owner_q, owner_d;
   logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   logic                  load;
   logic                  locked;
   logic                  cont;
   logic                  gv;
   logic [SEL_WIDTH-1:0]  grant;
   logic [DATA_WIDTH-1:0] gdata;

   always_comb begin
      load   = !valid_q || i_ready;
      locked = (cnt_q != '0);
      cont   = locked && i_valid[owner_q];
      gv     = 1'b0;
      grant  = '0;
      gdata  = '0;

      // Scan ptr..NUM_PORTS-1 first, then wrap to 0..ptr-1.
      if (cont) begin
         gv    = 1'b1;
         grant = owner_q;
      end else begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            if (!gv && i_valid[k] && (SEL_WIDTH'(k) >= ptr_q)) begin
               gv    = 1'b1;
               grant = SEL_WIDTH'(k);
            end
         end
         for (int k = 0; k < NUM_PORTS; k++) begin
            if (!gv && i_valid[k] && (SEL_WIDTH'(k) < ptr_q)) begin
               gv    = 1'b1;
               grant = SEL_WIDTH'(k);
            end
         end
      end

      for (int k = 0; k < NUM_PORTS; k++) begin
         if (grant == SEL_WIDTH'(k)) begin
            gdata = i_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      for (int k = 0; k < NUM_PORTS; k++) begin
         o_ready[k] = load && gv && (grant == SEL_WIDTH'(k));
      end

      valid_d = valid_q;
      data_d  = data_q;
      grant_d = grant_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;

      if (load) begin
         if (gv) begin
            valid_d = 1'b1;
            data_d  = gdata;
            grant_d = grant;
            owner_d = grant;
            cnt_d   = cont ? (cnt_q - CNT_WIDTH'(1)) : CNT_RELOAD;
            if (cnt_d == '0) begin
               ptr_d = next_port(grant);
            end
         end else begin
            valid_d = 1'b0;
            // Owner vanished mid-burst with nobody else asking: release the lock.
            if (locked) begin
               cnt_d = '0;
               ptr_d = next_port(owner_q);
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         grant_q <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_grant = grant_q;

endmodule

// File: doc/li_rr_arbiter.md
# li_rr_arbiter

Round-robin arbiter that shares one latency-insensitive valid/ready channel among NUM_PORTS upstream requesters. It merges their data streams onto a single registered output stage that downstream pipeline registers or a shell consumer can drain. A per-owner burst lock lets a requester keep the channel for up to BURST_LEN consecutive beats before the grant rotates. The block sits between several producer pearls and one shared downstream link in the LI shell.

## Interface
- DATA_WIDTH, 32: payload bits per beat.
- NUM_PORTS, 4: number of requesters; must be at least 2.
- BURST_LEN, 2: maximum beats per grant; must be at least 1. A value of 1 gives pure round-robin.
- SEL_WIDTH, $clog2(NUM_PORTS): width of the grant index.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- i_data  in  NUM_PORTS*DATA_WIDTH  requester payloads; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_valid  in  NUM_PORTS  per-requester valid.
- o_ready  out  NUM_PORTS  per-requester ready (accept strobe).
- o_data  out  DATA_WIDTH  registered output payload.
- o_valid  out  1  registered output valid.
- i_ready  in  1  downstream ready.
- o_grant  out  SEL_WIDTH  index of the requester whose beat is currently held in o_data.

## Operation
- Output stage:
  - load = !o_valid || i_ready.
  - A beat leaves the output stage when o_valid && i_ready.
- Registered state:
  - ptr: round-robin start index.
  - owner: SEL_WIDTH bits.
  - cnt: remaining lock beats, width $clog2(BURST_LEN+1).
  - locked = (cnt != 0).
- Grant selection, combinational, evaluated every cycle:
  - If locked && i_valid[owner]: grant = owner.
  - Otherwise grant = the first k with i_valid[k] set, scanning ptr, ptr+1, … modulo NUM_PORTS.
  - gv is set when a grant exists.
- o_ready[k] = load && gv && (k == grant). At most one bit is set. The path from i_ready to o_ready is combinational.
- Accept (load && gv):
  - o_data <= i_data[grant]
  - o_valid <= 1
  - o_grant <= grant
  - owner <= grant
  - If the grant continues the lock: cnt <= cnt - 1.
  - If it is a new grant: cnt <= BURST_LEN - 1.
  - If the new cnt is 0: ptr <= (grant + 1) mod NUM_PORTS.
- load && !gv: o_valid <= 0. o_data and o_grant hold.
- !load: all state holds.
- If locked and i_valid[owner] is low, the lock is abandoned in that same cycle. Arbitration is normal from ptr. If nothing is granted: cnt <= 0 and ptr <= (owner + 1) mod NUM_PORTS.
- The arbiter never drops or duplicates a beat. Each accepted beat appears on o_data exactly once, in acceptance order.

## Timing
- Reset values:
  - o_valid = 0, o_data = 0, o_grant = 0.
  - ptr = 0, owner = 0, cnt = 0.
  - o_ready is therefore all zeros until some i_valid is seen while load is 1.
- Reset asserted mid-transfer discards the held beat. o_valid falls asynchronously.
- Latency: 1 cycle from acceptance (o_ready[k] && i_valid[k]) to o_valid = 1 with that payload.
- Throughput: one beat per cycle while i_ready = 1.
- Backpressure (o_valid && !i_ready):
  - All o_ready bits are 0.
  - o_data, o_grant, ptr and cnt are frozen.
  - Arbitration resumes in the cycle i_ready returns.
- Simultaneous drain and accept: in one cycle the held beat leaves and the new beat loads. No bubble.

## Test plan
- Reset mid-stream: streaming from port 1, then assert reset for 1 cycle.
  - During reset: o_valid = 0, o_data = 0, o_grant = 0.
  - After release: the first grant goes to the lowest valid index starting from 0.
- Single requester: port 2 drives 0xA0, 0xA1, 0xA2 with i_ready = 1.
  - o_valid is high on cycles 1-3 with data 0xA0, 0xA1, 0xA2 in order.
  - o_grant = 2 throughout.
  - No bubble between beats.
- All four ports valid continuously, BURST_LEN = 2, i_ready = 1: o_grant sequence is 0,0,1,1,2,2,3,3,0,0.
- Backpressure: hold i_ready = 0 for 3 cycles while o_valid = 1 with 0x55.
  - o_data stays 0x55 and all o_ready bits stay 0 for those cycles.
  - On the cycle i_ready rises, the next beat is accepted and appears the cycle after.
- Owner drops mid-burst: port 1 is valid for one beat then drops; port 3 is valid.
  - The next grant is 3.
  - After port 3's 2-beat burst, ptr = 0.
- Wrap-around: ptr = 3 and ports 0 and 3 are valid, BURST_LEN = 1. Grants alternate 3,0,3,0.
